// File: rtl/fpu_addsub_param.sv
// Parametrised floating-point adder/subtractor with a valid/ready handshake.
// A multi-cycle FSM datapath runs ALIGN -> ADD -> NORM -> ROUND and then holds
// the result in DONE until the consumer accepts it.
// Format is {sign, exp, man} with a hidden leading 1. exp==0 means zero,
// and there are no denormals.
module fpu_addsub_param #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);

  // Significand field: hidden bit, fraction, guard, round, sticky
  localparam int SW = MAN_W + 4;
  localparam int LW = $clog2(SW);
  // Signed working exponent, wide enough for +1 carry and -LZC underflow
  localparam int XW = EXP_W + LW + 2;
  localparam int MW = MAN_W + 1;
  localparam logic [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic [XW-1:0] EXP_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q;
  logic          sign_q, eff_sub_q;
  logic [XW-1:0] exp_q;
  logic [SW-1:0] big_q, small_q, norm_q;
  logic [SW:0]   sum_q;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Alignment: order by magnitude, then shift the smaller one right with sticky
  logic              swap;
  logic [W-1:0]      big_w, small_w;
  logic [EXP_W-1:0]  big_exp, small_exp, diff;
  logic [SW-1:0]     big_sig, small_sig, small_al, lost;
  always_comb begin
    swap      = a_q[W-2:0] < b_q[W-2:0];
    big_w     = swap ? b_q : a_q;
    small_w   = swap ? a_q : b_q;
    big_exp   = big_w[W-2:MAN_W];
    small_exp = small_w[W-2:MAN_W];
    big_sig   = (big_exp == '0) ? '0 : {1'b1, big_w[MAN_W-1:0], 3'b000};
    small_sig = (small_exp == '0) ? '0 : {1'b1, small_w[MAN_W-1:0], 3'b000};
    diff      = big_exp - small_exp;
    lost      = '0;
    small_al  = '0;
    if (int'(diff) > MAN_W + 2) begin
      small_al = (small_sig != '0) ? SW'(1) : '0;
    end else begin
      small_al    = small_sig >> diff;
      lost        = small_sig & ((SW'(1) << diff) - SW'(1));
      small_al[0] = small_al[0] | (|lost);
    end
  end

  // Normalisation: carry-out shifts right, otherwise leading-zero left shift
  logic [LW-1:0] lzc;
  logic [SW-1:0] norm_w;
  logic [XW-1:0] exp_norm;
  always_comb begin
    lzc = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (sum_q[i]) lzc = LW'(SW - 1 - i);
    end
    norm_w   = sum_q[SW-1:0] << lzc;
    exp_norm = exp_q - XW'(lzc);
    if (sum_q[SW]) begin
      norm_w   = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      exp_norm = exp_q + EXP_ONE;
    end
  end

  // Rounding (nearest-even) and range/status classification.
  // A normalised non-zero significand always has its MSB set, so a clear MSB
  // marks an exact zero result without a separate flag register.
  logic          rnd_up, inexact, ovf, unf, is_zero;
  logic [MW-1:0] mant_r;
  logic [XW-1:0] exp_r;
  logic [W-1:0]  res_w;
  logic [3:0]    stat_w;
  always_comb begin
    is_zero = ~norm_q[SW-1];
    inexact = |norm_q[2:0];
    rnd_up  = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    mant_r  = {1'b0, norm_q[SW-2:3]} + MW'(rnd_up);
    exp_r   = mant_r[MAN_W] ? exp_q + EXP_ONE : exp_q;
    ovf     = $signed(exp_r) > $signed(EXP_MAX);
    unf     = $signed(exp_r) <= $signed(EXP_ZERO);
    res_w   = {sign_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
    stat_w  = inexact ? 4'b1000 : 4'b0001;
    if (unf) begin
      res_w  = {sign_q, {(W-1){1'b0}}};
      stat_w = 4'b0100;
    end
    if (ovf) begin
      res_w  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      stat_w = 4'b0010;
    end
    if (is_zero) begin
      res_w  = '0;
      stat_w = 4'b0001;
    end
  end

  // Datapath registers, one stage per FSM state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= '0;
      big_q      <= '0;
      small_q    <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
      data_out   <= '0;
      status_out <= 4'b0001;
    end else begin
      unique case (state_q)
        S_IDLE: if (in_valid) begin
          a_q <= op_A_in;
          b_q <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
        end
        S_ALIGN: begin
          sign_q    <= big_w[W-1];
          eff_sub_q <= big_w[W-1] ^ small_w[W-1];
          exp_q     <= XW'(big_exp);
          big_q     <= big_sig;
          small_q   <= small_al;
        end
        S_ADD: sum_q <= eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                  : ({1'b0, big_q} + {1'b0, small_q});
        S_NORM: begin
          norm_q <= norm_w;
          exp_q  <= exp_norm;
        end
        S_ROUND: begin
          data_out   <= res_w;
          status_out <= stat_w;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Directed bench for fpu_addsub_param: default format (6/25) plus an 8/23 instance.
module tb_fpu_addsub_param;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, op_sub, out_ready;
  logic [31:0] op_A_in, op_B_in;
  logic        in_ready, out_valid;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  logic        in_valid8, op_sub8, out_ready8;
  logic [31:0] op_A8, op_B8;
  logic        in_ready8, out_valid8;
  logic [31:0] data_out8;
  logic [3:0]  status_out8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fpu_addsub_param u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .op_A_in(op_A_in), .op_B_in(op_B_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status_out(status_out)
  );

  fpu_addsub_param #(.EXP_W(8), .MAN_W(23)) u_dut8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .op_sub(op_sub8),
    .op_A_in(op_A8), .op_B_in(op_B8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .data_out(data_out8), .status_out(status_out8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the default instance, checking latency and handshake
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] exp_d, input logic [3:0] exp_s);
    @(negedge clock);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    op_A_in = a; op_B_in = b; op_sub = sub; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, data_out, exp_d);
    chk({tag, "_status"}, 32'(status_out), 32'(exp_s));
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; op_sub = 1'b0; out_ready = 1'b0; op_A_in = '0; op_B_in = '0;
    in_valid8 = 1'b0; op_sub8 = 1'b0; out_ready8 = 1'b0; op_A8 = '0; op_B8 = '0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_status", 32'(status_out), 32'h1);
    reset = 1'b0;

    run_op("neg_add", 32'hBE000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'b0001);
    run_op("sub_neg", 32'h40000000, 32'h42000000, 1'b1, 32'hC0000000, 4'b0001);

    // Asynchronous reset while the block is in ALIGN
    @(negedge clock);
    op_A_in = 32'h3F000000; op_B_in = 32'h40400000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("align_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_data", data_out, 32'h0);
    chk("arst_status", 32'(status_out), 32'h1);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("arst_aborted", 32'(out_valid), 32'd0);

    run_op("cancel", 32'h3E000000, 32'hBE000000, 1'b0, 32'h00000000, 4'b0001);
    run_op("add_frac", 32'h3F000000, 32'h40400000, 1'b0, 32'h41C00000, 4'b0001);
    run_op("b_zero", 32'h3E000000, 32'h00000000, 1'b0, 32'h3E000000, 4'b0001);
    run_op("a_zero_sub", 32'h00000000, 32'h3E000000, 1'b1, 32'hBE000000, 4'b0001);
    run_op("overflow", 32'h7F000000, 32'h7F000000, 1'b0, 32'h7E000000, 4'b0010);
    run_op("tie_even", 32'h40000001, 32'h40000000, 1'b0, 32'h42000000, 4'b1000);
    run_op("tie_up", 32'h40000001, 32'h40000002, 1'b0, 32'h42000002, 4'b1000);
    run_op("guard_only", 32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b1000);
    run_op("sticky_only", 32'h3E000000, 32'h06000000, 1'b0, 32'h3E000000, 4'b1000);
    run_op("underflow", 32'h03000000, 32'h82000000, 1'b0, 32'h00000000, 4'b0100);

    // Backpressure: hold the result while a new request is presented
    @(negedge clock);
    op_A_in = 32'h3F000000; op_B_in = 32'h40400000; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("bp_valid", 32'(out_valid), 32'd1);
    op_A_in = 32'h3E000000; op_B_in = 32'h3E000000; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("bp_hold_data", data_out, 32'h41C00000);
      chk("bp_hold_status", 32'(status_out), 32'h1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clock);
    chk("bp_ignored", 32'(out_valid), 32'd0);
    run_op("bp_next", 32'h40000001, 32'h40000002, 1'b0, 32'h42000002, 4'b1000);

    // 8-bit exponent, 23-bit mantissa instance
    @(negedge clock);
    op_A8 = 32'h3F800000; op_B8 = 32'h3F800000; op_sub8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clock);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clock);
    chk("w8_add_early", 32'(out_valid8), 32'd0);
    @(negedge clock);
    chk("w8_add_valid", 32'(out_valid8), 32'd1);
    chk("w8_add_data", data_out8, 32'h40000000);
    chk("w8_add_status", 32'(status_out8), 32'h1);
    out_ready8 = 1'b1;
    @(negedge clock);
    out_ready8 = 1'b0;
    op_A8 = 32'h40000000; op_B8 = 32'h3F800000; op_sub8 = 1'b1; in_valid8 = 1'b1;
    @(negedge clock);
    in_valid8 = 1'b0;
    repeat (4) @(negedge clock);
    chk("w8_sub_valid", 32'(out_valid8), 32'd1);
    chk("w8_sub_data", data_out8, 32'h3F800000);
    chk("w8_sub_status", 32'(status_out8), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
